uio_bus_arbiter: RTL and testbench

//  Shares the bidirectional 8-bit uio pad bus of tt_um_s_grundner among N_REQ internal requesters.

---
 rtl/uio_arb_pkg.sv | 19 +
 rtl/uio_bus_arbiter_rr_pick.sv | 31 +++
 rtl/uio_bus_arbiter.sv | 158 +++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter.
// Bus direction encoding, pad width and the arbiter state type.
package uio_arb_pkg;

    localparam int   UIO_W      = 8;
    localparam logic DIR_DRIVE  = 1'b1;
    localparam logic DIR_SAMPLE = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        GRANT
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uio_bus_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr_i, wrapping around.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);

    int cand;

    // Scan from farthest to nearest so the nearest candidate is the last write.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr_i) + i) % N_REQ;
            if (req_i[cand]) begin
                valid_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the bidirectional uio pad bus among N_REQ requesters,
// with bounded bursts and released-pad turnaround cycles on direction change.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int MAX_BURST  = 8,
    parameter int TURNAROUND = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ-1:0]         dir_i,
    input  logic [UIO_W*N_REQ-1:0]   wdata_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic                     busy_o,
    output logic [UIO_W-1:0]         rdata_o,
    output logic                     rvalid_o,
    input  logic [UIO_W-1:0]         uio_in,
    output logic [UIO_W-1:0]         uio_out,
    output logic [UIO_W-1:0]         uio_oe
);

    localparam int IW = idx_width(N_REQ);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int TW = $clog2(TURNAROUND + 1);

    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURNAROUND - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             dir_q, dir_d;
    logic             last_dir_q, last_dir_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [TW-1:0]    turn_cnt_q, turn_cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [UIO_W-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [IW-1:0]    next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dir_d       = dir_q;
        last_dir_d  = last_dir_q;
        ptr_d       = ptr_q;
        burst_cnt_d = burst_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        gnt_d       = '0;
        next_ptr    = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (ena && pick_valid) begin
                    idx_d       = pick_idx;
                    dir_d       = dir_i[pick_idx];
                    burst_cnt_d = '0;
                    turn_cnt_d  = '0;
                    state_d     = (dir_i[pick_idx] != last_dir_q) ? TURN : GRANT;
                end
            end
            TURN: begin
                // An aborted turnaround still moves the pointer so the
                // interrupted requester does not keep first priority.
                if (!ena) begin
                    state_d    = IDLE;
                    ptr_d      = next_ptr;
                    turn_cnt_d = '0;
                end else if (turn_cnt_q == TURN_LAST) begin
                    state_d    = GRANT;
                    turn_cnt_d = '0;
                    last_dir_d = dir_q;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            GRANT: begin
                if (ena && dir_q == DIR_SAMPLE) begin
                    rdata_d  = uio_in;
                    rvalid_d = 1'b1;
                end
                if (!ena || !req_i[idx_q] || burst_cnt_q == BURST_LAST) begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                    ptr_d       = next_ptr;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == GRANT) begin
            gnt_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            dir_q       <= DIR_SAMPLE;
            last_dir_q  <= DIR_SAMPLE;
            ptr_q       <= '0;
            burst_cnt_q <= '0;
            turn_cnt_q  <= '0;
            gnt_q       <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            dir_q       <= dir_d;
            last_dir_q  <= last_dir_d;
            ptr_q       <= ptr_d;
            burst_cnt_q <= burst_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
            gnt_q       <= gnt_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Pads are only ever driven during a drive grant; everything else releases them.
    always_comb begin
        uio_out = '0;
        uio_oe  = '0;
        if (state_q == GRANT && dir_q == DIR_DRIVE) begin
            uio_oe  = '1;
            uio_out = wdata_i[idx_q*UIO_W +: UIO_W];
        end
    end

    assign gnt_o    = gnt_q;
    assign busy_o   = (state_q != IDLE);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: a transaction-level model predicts the
// outputs after every clock edge, and a monitor compares them against the DUT.
module tb_uio_bus_arbiter;

    localparam int N  = 3;
    localparam int MB = 8;
    localparam int TA = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic [N-1:0]   req;
    logic [N-1:0]   dir;
    logic [8*N-1:0] wdata;
    logic [7:0]     uio_in;
    logic [N-1:0]   gnt_o;
    logic           busy_o;
    logic [7:0]     rdata_o;
    logic           rvalid_o;
    logic [7:0]     uio_out;
    logic [7:0]     uio_oe;

    uio_bus_arbiter #(
        .N_REQ      (N),
        .MAX_BURST  (MB),
        .TURNAROUND (TA)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .req_i    (req),
        .dir_i    (dir),
        .wdata_i  (wdata),
        .gnt_o    (gnt_o),
        .busy_o   (busy_o),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .uio_in   (uio_in),
        .uio_out  (uio_out),
        .uio_oe   (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         busy;
        logic [7:0]   rdata;
        logic         rvalid;
        logic [7:0]   out;
        logic [7:0]   oe;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;
    exp_t mon_act;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Reference model: who owns the bus, how many turnaround cycles remain
    // before its grant starts, and how many grant beats it has used.
    int         m_owner;
    int         m_turn_left;
    int         m_beats;
    int         m_ptr;
    logic       m_dir;
    logic       m_last_dir;
    logic [7:0] m_rdata;

    task automatic model_reset();
        m_owner     = -1;
        m_turn_left = 0;
        m_beats     = 0;
        m_ptr       = 0;
        m_dir       = 1'b0;
        m_last_dir  = 1'b0;
        m_rdata     = 8'h00;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic e,
                        input logic [8*N-1:0] w, input logic [7:0] u);
        exp_t x;
        @(negedge clk);
        req = r; dir = d; ena = e; wdata = w; uio_in = u;
        x = '0;
        if (m_owner < 0) begin
            if (e && r != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_dir       = d[m_owner];
                m_turn_left = (m_dir != m_last_dir) ? TA : 0;
                m_beats     = 0;
            end
        end else if (m_turn_left > 0) begin
            if (!e) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_turn_left--;
                if (m_turn_left == 0) m_last_dir = m_dir;
            end
        end else begin
            if (e && !m_dir) begin
                m_rdata  = u;
                x.rvalid = 1'b1;
            end
            m_beats++;
            if (!e || !r[m_owner] || m_beats == MB) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
        x.busy  = (m_owner >= 0);
        x.rdata = m_rdata;
        if (m_owner >= 0 && m_turn_left == 0) begin
            x.gnt[m_owner] = 1'b1;
            if (m_dir) begin
                x.oe  = 8'hFF;
                x.out = w[m_owner*8 +: 8];
            end
        end
        sb.push_back(x);
        mon_en = 1'b1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_underflow at %0t: DUT output with nothing expected", $time);
            end else begin
                mon_exp = sb.pop_front();
                mon_act = {gnt_o, busy_o, rdata_o, rvalid_o, uio_out, uio_oe};
                if (mon_act !== mon_exp) begin
                    n_bad++;
                    $display("FAIL cycle_out at %0t got gnt=%b busy=%b rdata=%h rvalid=%b out=%h oe=%h want gnt=%b busy=%b rdata=%h rvalid=%b out=%h oe=%h",
                             $time, mon_act.gnt, mon_act.busy, mon_act.rdata, mon_act.rvalid, mon_act.out, mon_act.oe,
                             mon_exp.gnt, mon_exp.busy, mon_exp.rdata, mon_exp.rvalid, mon_exp.out, mon_exp.oe);
                end
            end
        end
    end

    task automatic check_released(input string tag);
        chk({tag, "_gnt"},    8'(gnt_o),  8'h00);
        chk({tag, "_busy"},   8'(busy_o), 8'h00);
        chk({tag, "_rvalid"}, 8'(rvalid_o), 8'h00);
        chk({tag, "_rdata"},  rdata_o,    8'h00);
        chk({tag, "_out"},    uio_out,    8'h00);
        chk({tag, "_oe"},     uio_oe,     8'h00);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_released("async_rst");
        req = '0; dir = '0; ena = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b1, 24'($urandom), 8'($urandom));
    endtask

    logic [N-1:0] r_req;
    logic [N-1:0] r_dir;

    initial begin
        rst_n = 1'b0; ena = 1'b1; req = '0; dir = '0; wdata = '0; uio_in = '0;
        model_reset();
        #12;
        check_released("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Drive grant from requester 0 after reset: one TURN, then pads driven with A5.
        for (int i = 0; i < 4; i++) step(3'b001, 3'b001, 1'b1, {16'h0000, 8'hA5}, 8'h00);
        do_reset();

        // All requesters sampling: full bursts in round-robin order, no TURN.
        for (int i = 0; i < 40; i++) step(3'b111, 3'b000, 1'b1, 24'($urandom), 8'($urandom));
        idle_steps(3);

        // Single sample grant capturing 3C, then dropped request.
        for (int i = 0; i < 3; i++) step(3'b010, 3'b000, 1'b1, 24'($urandom), 8'h3C);
        idle_steps(2);

        // Enable dropped mid-grant of requester 1, then everyone requests.
        for (int i = 0; i < 2; i++) step(3'b010, 3'b000, 1'b1, 24'($urandom), 8'($urandom));
        step(3'b010, 3'b000, 1'b0, 24'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) step(3'b111, 3'b000, 1'b1, 24'($urandom), 8'($urandom));
        idle_steps(2);

        // Direction flip during a sample grant is ignored; the next grant turns around.
        for (int i = 0; i < 3; i++) step(3'b001, 3'b000, 1'b1, 24'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++) step(3'b001, 3'b001, 1'b1, 24'($urandom), 8'($urandom));
        idle_steps(2);
        for (int i = 0; i < 4; i++) step(3'b001, 3'b001, 1'b1, 24'($urandom), 8'($urandom));
        idle_steps(2);

        // Randomized traffic with sticky requests and occasional enable drops.
        r_req = '0; r_dir = '0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r_req = 3'($urandom);
            if ($urandom_range(0, 3) == 0) r_dir = 3'($urandom);
            step(r_req, r_dir, ($urandom_range(0, 19) != 0), 24'($urandom), 8'($urandom));
            if (i == 400) do_reset();
        end
        idle_steps(2);

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("sb_drained", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
